// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the frame-sum accumulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: FSM state encoding, LEN field width, LEN=0 mapping constant and
// a helper that turns a LEN field into a "samples minus one" counter load.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int LEN_W = 4;

  // A LEN field of zero stands for the largest frame the field can express.
  localparam logic [LEN_W:0] LEN_ZERO_MAP = 5'd16;

  // Sample counter is loaded with (frame length - 1) so the zero flag marks
  // the cycle that adds the final sample.
  function automatic logic [LEN_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] eff;
    eff = (len == '0) ? LEN_ZERO_MAP : {1'b0, len};
    return LEN_W'(eff - 5'd1);
  endfunction

endpackage

// File: rtl/sum_frame_accum_if.sv
// Frame request / sample / result bundle between a frame consumer and the accumulator.
// Latency: none (wires only).
// Backpressure: RESULT/OVF are held by the slave while OUT_VALID=1 and OUT_READY=0.
//
// master drives START, LEN, IN_DATA, OUT_READY and observes RESULT, OVF,
// OUT_VALID, BUSY; slave is the accumulator side.
interface sum_frame_accum_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  logic                          START;
  logic [sum_accum_pkg::LEN_W-1:0] LEN;
  logic [WIDTH-1:0]              IN_DATA;
  logic [ACC_WIDTH-1:0]          RESULT;
  logic                          OVF;
  logic                          OUT_VALID;
  logic                          OUT_READY;
  logic                          BUSY;

  modport master (
    output START, LEN, IN_DATA, OUT_READY,
    input  RESULT, OVF, OUT_VALID, BUSY
  );

  modport slave (
    input  START, LEN, IN_DATA, OUT_READY,
    output RESULT, OVF, OUT_VALID, BUSY
  );
endinterface

// File: rtl/sum_frame_accum_ce_down_counter.sv
// Loadable down-counter that only steps on clock-enabled cycles, with a zero flag.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: none; decrement is frozen by CE=0 or en=0 and stops at zero.
//
// Ports: CLK, RST (sync, active-high), CE, load/load_val, en (decrement
// request), zero (count is zero).
module ce_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (CE && en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sum_frame_accum.sv
// Sums LEN samples from a CE-gated adder pipeline after skipping its PIPE_LAT fill cycles.
// Latency: OUT_VALID rises 1+PIPE_LAT+LEN cycles after START with CE held high.
// Backpressure: RESULT/OVF held in DONE until OUT_READY; handshake ignores CE.
//
// Ports: CLK, RST (sync, active-high), CE (shared with upstream pipeline),
// bus (slave side of sum_frame_accum_if: START, LEN, IN_DATA, RESULT, OVF,
// OUT_VALID, OUT_READY, BUSY). IN_DATA is zero-extended, so WIDTH is
// expected not to exceed ACC_WIDTH.
module sum_frame_accum
  import sum_accum_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int PIPE_LAT  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  sum_frame_accum_if.slave   bus
);

  // Fill counter holds PIPE_LAT-1 down to 0; PIPE_LAT is expected to be >= 1.
  localparam int FILL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic                 out_valid;
  logic                 busy;

  logic                 frame_start;
  logic                 fill_zero;
  logic                 samp_zero;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 clip;

  // A new frame may begin from IDLE, or straight out of DONE when the
  // current result is being accepted in the same cycle.
  assign frame_start = bus.START &&
                       ((state == ST_IDLE) || ((state == ST_DONE) && bus.OUT_READY));

  // One extra bit catches the carry that means the addition would clip.
  assign sum_ext = {1'b0, acc} + (ACC_WIDTH+1)'(bus.IN_DATA);
  assign clip    = sum_ext[ACC_WIDTH];

  ce_down_counter #(.WIDTH(FILL_W)) u_fill_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .load     (frame_start),
    .load_val (FILL_W'(PIPE_LAT - 1)),
    .en       (state == ST_FILL),
    .zero     (fill_zero)
  );

  ce_down_counter #(.WIDTH(LEN_W)) u_samp_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .load     (frame_start),
    .load_val (len_to_count(bus.LEN)),
    .en       (state == ST_ACCUM),
    .zero     (samp_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_FILL;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          // Counter reads zero during the last fill cycle, so leave on that CE edge.
          if (CE && fill_zero) begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (CE) begin
            acc <= clip ? '1 : sum_ext[ACC_WIDTH-1:0];
            ovf <= ovf | clip;
            if (samp_zero) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.OUT_READY) begin
            out_valid <= 1'b0;
            if (frame_start) begin
              state <= ST_FILL;
              acc   <= '0;
              ovf   <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RESULT    = acc;
  assign bus.OVF       = ovf;
  assign bus.OUT_VALID = out_valid;
  assign bus.BUSY      = busy;

endmodule
